// File: rtl/ttl_74165_sync.sv
// 74165-style parallel-in / serial-out shift register, BLOCKS independent lanes of WIDTH stages.
// Each lane loads a word synchronously and shifts it out MSB-first on Q.
module ttl_74165_sync #(
    parameter int BLOCKS     = 2,
    parameter int WIDTH      = 8,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [BLOCKS-1:0]         Load_bar,
    input  logic [BLOCKS-1:0]         Clk_inhibit,
    input  logic [BLOCKS-1:0]         DS,
    input  logic [BLOCKS*WIDTH-1:0]   D_2D,
    output logic [BLOCKS-1:0]         Q,
    output logic [BLOCKS-1:0]         Q_bar,
    output logic [BLOCKS*WIDTH-1:0]   Q_2D
);

    // Output delays only describe the behavioural model; the hardware updates at the edge.
    if (WIDTH < 2 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_param_check
        $error("ttl_74165_sync: WIDTH must be >= 2 and delays non-negative");
    end

    logic [WIDTH-1:0]  d_s      [BLOCKS];
    logic [WIDTH-1:0]  s_next_s [BLOCKS];
    logic [WIDTH-1:0]  s_r      [BLOCKS];
    logic [BLOCKS-1:0] q_bar_r;

    // Split the packed parallel bus into one word per lane.
    always_comb begin
        for (int b = 0; b < BLOCKS; b++) begin
            d_s[b] = D_2D[b*WIDTH +: WIDTH];
        end
    end

    // Per-lane next state: load beats inhibit, inhibit beats shift.
    always_comb begin
        for (int b = 0; b < BLOCKS; b++) begin
            s_next_s[b] = s_r[b];
            if (!Load_bar[b]) begin
                s_next_s[b] = d_s[b];
            end else if (Clk_inhibit[b]) begin
                s_next_s[b] = s_r[b];
            end else begin
                s_next_s[b] = {s_r[b][WIDTH-2:0], DS[b]};
            end
        end
    end

    // Stage registers; the complement output is kept as its own flop so it is registered too.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int b = 0; b < BLOCKS; b++) begin
                s_r[b] <= '0;
            end
            q_bar_r <= '1;
        end else begin
            for (int b = 0; b < BLOCKS; b++) begin
                s_r[b]     <= s_next_s[b];
                q_bar_r[b] <= ~s_next_s[b][WIDTH-1];
            end
        end
    end

    // Drive the serial and packed outputs straight from the stage flops.
    always_comb begin
        Q    = '0;
        Q_2D = '0;
        for (int b = 0; b < BLOCKS; b++) begin
            Q[b]                  = s_r[b][WIDTH-1];
            Q_2D[b*WIDTH +: WIDTH] = s_r[b];
        end
    end

    assign Q_bar = q_bar_r;

endmodule

// File: tb/tb_ttl_74165_sync.sv
// Scoreboard bench for ttl_74165_sync (BLOCKS=2, WIDTH=8): stimulus pushes hand-computed
// expectations, a monitor pops one per clock and compares Q_2D, Q and Q_bar.
module tb_ttl_74165_sync;

    logic        clk;
    logic        rst;
    logic [1:0]  load_bar;
    logic [1:0]  inhibit;
    logic [1:0]  ds;
    logic [15:0] d;
    logic [1:0]  q;
    logic [1:0]  q_bar;
    logic [15:0] q_2d;

    typedef struct {
        string       name;
        logic [15:0] q2d;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    ttl_74165_sync #(.BLOCKS(2), .WIDTH(8), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
        .Clk         (clk),
        .Reset       (rst),
        .Load_bar    (load_bar),
        .Clk_inhibit (inhibit),
        .DS          (ds),
        .D_2D        (d),
        .Q           (q),
        .Q_bar       (q_bar),
        .Q_2D        (q_2d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one expectation is consumed after every rising edge that has one queued.
    initial begin
        exp_t        e;
        logic [1:0]  eq;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                eq = {e.q2d[15], e.q2d[7]};
                checks++;
                if (q_2d !== e.q2d) begin
                    errors++;
                    $display("FAIL %s Q_2D: got %h expected %h", e.name, q_2d, e.q2d);
                end
                checks++;
                if (q !== eq) begin
                    errors++;
                    $display("FAIL %s Q: got %b expected %b", e.name, q, eq);
                end
                checks++;
                if (q_bar !== ~eq) begin
                    errors++;
                    $display("FAIL %s Q_bar: got %b expected %b", e.name, q_bar, ~eq);
                end
            end
        end
    end

    task automatic step(input string name, input logic r, input logic [1:0] lb,
                        input logic [1:0] inh, input logic [1:0] s, input logic [15:0] dv,
                        input logic [15:0] exp_q2d);
        exp_t e;
        @(negedge clk);
        rst      = r;
        load_bar = lb;
        inhibit  = inh;
        ds       = s;
        d        = dv;
        e.name   = name;
        e.q2d    = exp_q2d;
        sb.push_back(e);
    endtask

    // Block 0 shift-out of A5 with block 1 held, one entry per edge.
    logic [15:0] shift_a5 [8] = '{16'h004A, 16'h0094, 16'h0028, 16'h0050,
                                  16'h00A0, 16'h0040, 16'h0080, 16'h0000};

    initial begin
        rst = 1'b1; load_bar = 2'b11; inhibit = 2'b00; ds = 2'b00; d = 16'h0000;

        // Reset from a non-zero state
        step("prime_load", 1'b0, 2'b00, 2'b00, 2'b00, 16'h5AC3, 16'h5AC3);
        step("reset",      1'b1, 2'b11, 2'b00, 2'b00, 16'h1234, 16'h0000);

        // Load A5 into block 0 and shift it out
        step("load_a5",    1'b0, 2'b10, 2'b10, 2'b00, 16'h00A5, 16'h00A5);
        for (int i = 0; i < 8; i++) begin
            step($sformatf("shift_a5_%0d", i), 1'b0, 2'b11, 2'b10, 2'b00, 16'h0000, shift_a5[i]);
        end

        // Serial fill of block 1 with ones
        step("fill_reset", 1'b1, 2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] fill;
            fill = 8'((9'h002 << i) - 9'h001);
            step($sformatf("fill_%0d", i), 1'b0, 2'b11, 2'b01, 2'b10, 16'h0000, {fill, 8'h00});
        end

        // Inhibit on block 0 while block 1 keeps shifting zeros in
        step("inh_load",   1'b0, 2'b10, 2'b00, 2'b00, 16'h0080, 16'hFE80);
        step("inh_0",      1'b0, 2'b11, 2'b01, 2'b00, 16'h0000, 16'hFC80);
        step("inh_1",      1'b0, 2'b11, 2'b01, 2'b00, 16'h0000, 16'hF880);
        step("inh_2",      1'b0, 2'b11, 2'b01, 2'b00, 16'h0000, 16'hF080);
        step("inh_shift",  1'b0, 2'b11, 2'b00, 2'b00, 16'h0000, 16'hE000);

        // Priority: reset over load, then load over inhibit
        step("prio_reset", 1'b1, 2'b00, 2'b00, 2'b00, 16'hFFFF, 16'h0000);
        step("prio_load",  1'b0, 2'b10, 2'b01, 2'b00, 16'h003C, 16'h003C);

        // Reset mid-stream, then the next edge loads normally
        step("mid_load",   1'b0, 2'b10, 2'b10, 2'b00, 16'h00FF, 16'h00FF);
        step("mid_sh0",    1'b0, 2'b11, 2'b10, 2'b00, 16'h0000, 16'h00FE);
        step("mid_sh1",    1'b0, 2'b11, 2'b10, 2'b00, 16'h0000, 16'h00FC);
        step("mid_sh2",    1'b0, 2'b11, 2'b10, 2'b00, 16'h0000, 16'h00F8);
        step("mid_reset",  1'b1, 2'b11, 2'b10, 2'b00, 16'h0000, 16'h0000);
        step("mid_load01", 1'b0, 2'b10, 2'b10, 2'b00, 16'h0001, 16'h0001);

        // Load held low reloads every edge; then both lanes shift ones in
        step("hold_load0", 1'b0, 2'b00, 2'b00, 2'b00, 16'h81C3, 16'h81C3);
        step("hold_load1", 1'b0, 2'b00, 2'b11, 2'b00, 16'h81C3, 16'h81C3);
        step("both_shift", 1'b0, 2'b11, 2'b00, 2'b11, 16'h0000, 16'h0387);

        @(negedge clk);
        rst = 1'b0; load_bar = 2'b11; inhibit = 2'b11;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ttl_74165_sync.md
# ttl_74165_sync

Parallel-in, serial-out shift register in the style of the 74165, provided as `BLOCKS` independent shift registers of `WIDTH` stages each. Each block captures a parallel word and shifts it out MSB-first on `Q`, one stage per enabled clock. It is the transmit-side counterpart to the library's gated serial-in, parallel-out register. Loading is synchronous, and the model has a synchronous clear.

## Interface
Parameters:
- `BLOCKS`, default 2: number of independent shift registers.
- `WIDTH`, default 8: stages per register; must be ≥ 2.
- `DELAY_RISE`, default 0: rise delay applied to all outputs.
- `DELAY_FALL`, default 0: fall delay applied to all outputs.

Ports:
- `Clk`  input  1: single clock; all state changes on the rising edge.
- `Reset`  input  1: synchronous, active-high clear of every stage in every block.
- `Load_bar`  input  BLOCKS: per-block active-low synchronous parallel load.
- `Clk_inhibit`  input  BLOCKS: per-block active-high shift hold.
- `DS`  input  BLOCKS: per-block serial data into stage 0.
- `D_2D`  input  BLOCKS*WIDTH: packed parallel words; block b occupies bits `[b*WIDTH +: WIDTH]`. It is unpacked with `ASSIGN_UNPACK_ARRAY`.
- `Q`  output  BLOCKS: per-block last stage (stage `WIDTH-1`).
- `Q_bar`  output  BLOCKS: bitwise complement of `Q`.
- `Q_2D`  output  BLOCKS*WIDTH: packed stage contents, in the same packing as `D_2D`.

## Operation
- Each block holds a register S[b] with bits `[WIDTH-1:0]`, where stage 0 is the serial input end.
- Actions at each rising `Clk` edge, per block b, in priority order:
  1. `Reset` = 1: S[b] ← 0.
  2. `Load_bar[b]` = 0: S[b] ← D[b].
  3. `Clk_inhibit[b]` = 1: S[b] holds.
  4. Otherwise (shift): S[b][0] ← `DS[b]`, and S[b][i] ← S[b][i-1] for i = 1..`WIDTH-1`.
- Outputs:
  - `Q[b]` = S[b][`WIDTH-1`].
  - `Q_bar[b]` = ~S[b][`WIDTH-1`].
  - `Q_2D` block b = S[b].
- Reset values: every S = 0, so `Q` = 0, `Q_bar` = all ones and `Q_2D` = 0.
- Blocks are fully independent. Only `Clk` and `Reset` are shared.
- Load takes precedence over inhibit. Reset takes precedence over everything.
- Shifting is not circular: stage `WIDTH-1` is discarded at each shift, and nothing wraps.
- No async paths; inputs are sampled only at the rising edge.

## Timing
- Latency from a load edge n: `Q` = D[b][`WIDTH-1`] after edge n, and D[b][`WIDTH-1-k`] after k further shift edges. The word is fully emitted after `WIDTH-1` shifts.
- A `DS` value sampled at edge m reaches `Q` after edge m+`WIDTH-1`.
- An inhibited edge does not advance the count.
- Reset asserted mid-stream clears at that edge. The first edge with `Reset` = 0 acts normally, for example a load.
- `Load_bar` held low continuously reloads every edge, so `Q` stays D[`WIDTH-1`].
- Output delays:
  - All outputs use `DELAY_RISE`/`DELAY_FALL`. With zero delays they update in the same timestep as the edge.
  - `Q` and `Q_bar` transition at the same edge and are never equal after settling.

## Test plan
Every scenario uses `BLOCKS` = 2 and `WIDTH` = 8.
- **Reset:** assert `Reset` for one edge with arbitrary prior state → `Q` = 2'b00, `Q_bar` = 2'b11, `Q_2D` = 16'h0000.
- **Load and shift-out:**
  - Stimulus: block 0 loads 8'hA5 (`Load_bar[0]` = 0 for one edge), then 7 shifts with `DS[0]` = 0.
  - Response: `Q[0]` sequence 1,0,1,0,0,1,0,1; `Q_2D` block 0 = 8'h00 after one further shift.
- **Serial fill:**
  - Stimulus: block 1 is reset, then `DS[1]` = 1 for 8 shifts.
  - Response: `Q[1]` first becomes 1 after the 8th edge; `Q_2D` block 1 goes 8'h01, 8'h03, …, 8'hFF.
- **Inhibit:**
  - Stimulus: block 0 loads 8'h80, then `Clk_inhibit[0]` = 1 for 3 edges, then one shift.
  - Response: `Q[0]` stays 1 for 3 edges, then 0. Block 1 shifts unaffected during this time.
- **Priority:**
  - Stimulus: at one edge, `Reset` = 1, `Load_bar` = 2'b00, `D` = 16'hFFFF.
  - Response: all zeros.
  - Stimulus: next edge, `Reset` = 0, `Load_bar[0]` = 0, `Clk_inhibit[0]` = 1, D[0] = 8'h3C.
  - Response: block 0 = 8'h3C.
- **Reset mid-stream:**
  - Stimulus: block 0 loads 8'hFF, 3 shifts, then `Reset` for one edge, then a load of 8'h01.
  - Response: `Q_2D` block 0 = 8'h00 after the reset edge, then 8'h01 with `Q[0]` = 0.
